// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: op codes, legal-code check and FSM encoding shared by the arbiter
package alu_arbiter_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  function automatic logic is_legal(input logic [3:0] c);
    return c inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASS};
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester, shared-ALU and response signals of the arbiter
interface alu_arbiter_if #(parameter int WIDTH = 64);
  logic             Req0Valid, Req1Valid, Req0Ready, Req1Ready;
  logic [WIDTH-1:0] Req0A, Req0B, Req1A, Req1B;
  logic [3:0]       Req0Ctrl, Req1Ctrl, AluCtrl;
  logic [WIDTH-1:0] AluBusA, AluBusB, AluBusW, RespW;
  logic             AluZero, RespValid, RespReady, RespId, RespZero, RespErr;
  modport slave (
    input  Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Ctrl, Req1Ctrl,
           AluBusW, AluZero, RespReady,
    output Req0Ready, Req1Ready, AluBusA, AluBusB, AluCtrl,
           RespValid, RespId, RespW, RespZero, RespErr
  );
  modport master (
    output Req0Valid, Req1Valid, Req0A, Req0B, Req1A, Req1B, Req0Ctrl, Req1Ctrl,
           AluBusW, AluZero, RespReady,
    input  Req0Ready, Req1Ready, AluBusA, AluBusB, AluCtrl,
           RespValid, RespId, RespW, RespZero, RespErr
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the requester not granted last
module rr_arb2 (
  input  logic [1:0] Valid,
  input  logic       LastGrant,
  output logic [1:0] Grant
);
  always_comb begin
    Grant = &Valid ? (LastGrant ? 2'b01 : 2'b10) : Valid;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters, one operation at a time
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic         Clk,
  input logic         Reset,
  alu_arbiter_if.slave bus
);
  logic [1:0]       state_q, state_d, grant;
  logic             last_q, last_d, err_q, err_d, take, exec;
  logic             rid_q, rid_d, rzero_q, rzero_d, rerr_q, rerr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, sel_a, sel_b;
  logic [3:0]       ctrl_q, ctrl_d, sel_ctrl;

  rr_arb2 u_arb (
    .Valid     ({bus.Req1Valid, bus.Req0Valid}),
    .LastGrant (last_q),
    .Grant     (grant)
  );

  // operand registers double as the ALU bus drivers, so they hold outside EXEC
  always_comb begin
    take     = (state_q == IDLE) && (|grant);
    exec     = (state_q == EXEC);
    sel_a    = grant[1] ? bus.Req1A : bus.Req0A;
    sel_b    = grant[1] ? bus.Req1B : bus.Req0B;
    sel_ctrl = grant[1] ? bus.Req1Ctrl : bus.Req0Ctrl;
    state_d  = (state_q == IDLE) ? (take ? EXEC : IDLE) :
               exec ? RESP : (bus.RespReady ? IDLE : RESP);
    last_d   = take ? grant[1] : last_q;
    a_d      = take ? sel_a : a_q;
    b_d      = take ? sel_b : b_q;
    ctrl_d   = (take && is_legal(sel_ctrl)) ? sel_ctrl : ctrl_q;
    err_d    = take ? !is_legal(sel_ctrl) : err_q;
    w_d      = exec ? (err_q ? '0 : bus.AluBusW) : w_q;
    rzero_d  = exec ? (!err_q && bus.AluZero) : rzero_q;
    rerr_d   = exec ? err_q : rerr_q;
    rid_d    = exec ? last_q : rid_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= OP_AND;
      w_q     <= '0;
      rzero_q <= 1'b0;
      rerr_q  <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      w_q     <= w_d;
      rzero_q <= rzero_d;
      rerr_q  <= rerr_d;
      rid_q   <= rid_d;
    end
  end

  assign bus.Req0Ready = take && grant[0] && !Reset;
  assign bus.Req1Ready = take && grant[1] && !Reset;
  assign bus.AluBusA   = a_q;
  assign bus.AluBusB   = b_q;
  assign bus.AluCtrl   = ctrl_q;
  assign bus.RespValid = (state_q == RESP);
  assign bus.RespId    = rid_q;
  assign bus.RespW     = w_q;
  assign bus.RespZero  = rzero_q;
  assign bus.RespErr   = rerr_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure, errors and reset
module tb_alu_arbiter;
  logic Clk = 0, Reset = 1;
  int   checks = 0, errors = 0;
  logic zero_force = 0;
  alu_arbiter_if #(.WIDTH(64)) bus ();
  alu_arbiter #(.WIDTH(64)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  // behavioural stand-in for the external ALU; zero_force lets a test drive AluZero directly
  always_comb begin
    bus.AluBusW = bus.AluCtrl == 4'b0000 ? bus.AluBusA & bus.AluBusB :
                  bus.AluCtrl == 4'b0001 ? bus.AluBusA | bus.AluBusB :
                  bus.AluCtrl == 4'b0010 ? bus.AluBusA + bus.AluBusB :
                  bus.AluCtrl == 4'b0110 ? bus.AluBusA - bus.AluBusB :
                  bus.AluCtrl == 4'b0111 ? bus.AluBusB : 64'd0;
    bus.AluZero = (bus.AluBusW == 64'd0) || zero_force;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic resp(input string tag, input logic id, input logic [63:0] w,
                      input logic z, input logic e);
    chk({tag, "_valid"}, bus.RespValid, 1'b1);
    chk({tag, "_id"}, bus.RespId, id);
    chk({tag, "_w"}, bus.RespW, w);
    chk({tag, "_zero"}, bus.RespZero, z);
    chk({tag, "_err"}, bus.RespErr, e);
  endtask

  initial begin
    bus.Req0Valid = 1; bus.Req1Valid = 0; bus.RespReady = 1;
    bus.Req0A = 0; bus.Req0B = 0; bus.Req1A = 0; bus.Req1B = 0;
    bus.Req0Ctrl = 4'b0010; bus.Req1Ctrl = 4'b0010;
    nxt(); nxt(); smp();
    chk("rst_ready0", bus.Req0Ready, 1'b0);
    chk("rst_valid", bus.RespValid, 1'b0);
    chk("rst_w", bus.RespW, 64'd0);
    chk("rst_busa", bus.AluBusA, 64'd0);
    chk("rst_ctrl", bus.AluCtrl, 4'b0000);
    nxt(); Reset = 0; bus.Req0Valid = 0; nxt();

    // single ADD 5+7
    bus.Req0Valid = 1; bus.Req0A = 5; bus.Req0B = 7; bus.Req0Ctrl = 4'b0010;
    smp(); chk("add_ready0", bus.Req0Ready, 1'b1); chk("add_ready1", bus.Req1Ready, 1'b0);
    nxt(); bus.Req0Valid = 0;
    smp(); chk("add_exec_busa", bus.AluBusA, 64'd5); chk("add_exec_ctrl", bus.AluCtrl, 4'b0010);
    chk("add_exec_valid", bus.RespValid, 1'b0);
    nxt(); smp(); resp("add", 1'b0, 64'd12, 1'b0, 1'b0);
    nxt(); smp(); chk("add_done_valid", bus.RespValid, 1'b0);

    // tie from reset: Req0, then Req1, then Req0
    nxt(); Reset = 1; nxt(); Reset = 0;
    bus.Req0Valid = 1; bus.Req0A = 64'hf0; bus.Req0B = 64'h3c; bus.Req0Ctrl = 4'b0000;
    bus.Req1Valid = 1; bus.Req1A = 64'h0f; bus.Req1B = 64'h30; bus.Req1Ctrl = 4'b0001;
    smp(); chk("tie1_ready0", bus.Req0Ready, 1'b1); chk("tie1_ready1", bus.Req1Ready, 1'b0);
    nxt(); bus.Req0Valid = 0;
    smp(); chk("tie1_exec_ready1", bus.Req1Ready, 1'b0);
    nxt(); smp(); resp("tie1", 1'b0, 64'h30, 1'b0, 1'b0);
    chk("tie1_resp_ready1", bus.Req1Ready, 1'b0);
    nxt(); bus.Req0Valid = 1; bus.Req0A = 1; bus.Req0B = 1; bus.Req0Ctrl = 4'b0010;
    smp(); chk("tie2_ready1", bus.Req1Ready, 1'b1); chk("tie2_ready0", bus.Req0Ready, 1'b0);
    nxt(); bus.Req1Valid = 0; nxt(); smp(); resp("tie2", 1'b1, 64'h3f, 1'b0, 1'b0);
    nxt(); bus.Req1Valid = 1; bus.Req1A = 0; bus.Req1B = 64'h55; bus.Req1Ctrl = 4'b0111;
    bus.RespReady = 0;
    smp(); chk("tie3_ready0", bus.Req0Ready, 1'b1); chk("tie3_ready1", bus.Req1Ready, 1'b0);
    nxt(); bus.Req0Valid = 0; nxt();

    // backpressure: five stalled RESP cycles with Req1 still waiting
    for (int i = 0; i < 5; i++) begin
      smp(); resp("bp", 1'b0, 64'd2, 1'b0, 1'b0);
      chk("bp_ready1", bus.Req1Ready, 1'b0);
      nxt();
    end
    bus.RespReady = 1; nxt();
    smp(); chk("pass_ready1", bus.Req1Ready, 1'b1);
    nxt(); bus.Req1Valid = 0;
    smp(); chk("pass_ctrl", bus.AluCtrl, 4'b0111);
    nxt(); smp(); resp("pass", 1'b1, 64'h55, 1'b0, 1'b0);

    // illegal op on Req1
    nxt(); bus.Req1Valid = 1; bus.Req1A = 3; bus.Req1B = 4; bus.Req1Ctrl = 4'b1111;
    smp(); chk("ill_ready1", bus.Req1Ready, 1'b1);
    nxt(); bus.Req1Valid = 0;
    smp(); chk("ill_exec_ctrl", bus.AluCtrl, 4'b0111);
    nxt(); smp(); resp("ill", 1'b1, 64'd0, 1'b0, 1'b1);
    chk("ill_resp_ctrl", bus.AluCtrl, 4'b0111);

    // SUB 9-0 with the ALU reporting zero
    nxt(); bus.Req0Valid = 1; bus.Req0A = 9; bus.Req0B = 0; bus.Req0Ctrl = 4'b0110;
    zero_force = 1;
    smp(); chk("sub_ready0", bus.Req0Ready, 1'b1);
    nxt(); bus.Req0Valid = 0; nxt(); smp(); resp("sub", 1'b0, 64'd9, 1'b1, 1'b0);
    nxt(); zero_force = 0;

    // reset while in EXEC
    bus.Req0Valid = 1; bus.Req0A = 2; bus.Req0B = 3; bus.Req0Ctrl = 4'b0010;
    smp(); chk("rx_ready0", bus.Req0Ready, 1'b1);
    nxt(); bus.Req0Valid = 0; Reset = 1;
    nxt(); Reset = 0;
    smp(); chk("rx_valid", bus.RespValid, 1'b0); chk("rx_busa", bus.AluBusA, 64'd0);
    chk("rx_busb", bus.AluBusB, 64'd0); chk("rx_ctrl", bus.AluCtrl, 4'b0000);
    chk("rx_w", bus.RespW, 64'd0); chk("rx_id", bus.RespId, 1'b0);
    chk("rx_zero", bus.RespZero, 1'b0); chk("rx_err", bus.RespErr, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nxt(); smp(); chk("rx_no_resp", bus.RespValid, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits; all bus widths below follow it.
REQ-002 The design SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: Clk  input  1  rising-edge clock for all state.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Ports: Req0Valid / Req1Valid  input  1  requester n presents an operation.
REQ-006 Ports: Req0Ready / Req1Ready  output  1  the arbiter accepts requester n's operation this cycle.
REQ-007 Ports: Req0A, Req0B / Req1A, Req1B  input  WIDTH  operands for requester n.
REQ-008 Ports: Req0Ctrl / Req1Ctrl  input  4  ALU op code for requester n.
REQ-009 Ports: AluBusA, AluBusB  output  WIDTH  operands driven to the shared ALU.
REQ-010 Port: AluCtrl  output  4  op code driven to the shared ALU.
REQ-011 Ports: AluBusW  input  WIDTH, and AluZero  input  1  ALU result and zero flag.
REQ-012 Port: RespValid  output  1  a response is held on the Resp* outputs.
REQ-013 Port: RespReady  input  1  the consumer takes the response.
REQ-014 Ports: RespId  output  1  requester index; RespW  output  WIDTH  result; RespZero  output  1  zero flag; RespErr  output  1  illegal op code.

Function
REQ-015 Legal op codes SHALL be AND=0000, OR=0001, ADD=0010, SUB=0110 and PassB=0111; every other code is illegal.
REQ-016 FSM states SHALL be IDLE, EXEC and RESP.
REQ-017 IDLE transitions:
- any ReqnValid: grant exactly one requester, assert its ReqnReady combinationally, register its A/B/Ctrl and id, go to EXEC.
- no ReqnValid: stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
- both valid: grant the requester not granted last.
- only one valid: grant that requester, regardless of history.
- LastGrant resets to 1, so requester 0 wins the first tie.
REQ-019 ReqnReady SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester in IDLE.
REQ-020 EXEC behaviour:
- AluBusA, AluBusB and AluCtrl are driven from the registered operands.
- AluBusW and AluZero are captured into the response registers at the end of the cycle.
- Next state is RESP.
REQ-021 Outside EXEC, AluBusA and AluBusB SHALL hold their last values and AluCtrl SHALL hold the last legal code, so that the ALU never sees a new or illegal code.
REQ-022 Illegal op code on the granted request:
- the ALU is not driven with the code; AluCtrl holds its previous value.
- RespErr=1, RespW=0, RespZero=0.
- Timing is the same as a legal operation.
REQ-023 RespZero SHALL be copied unchanged from AluZero; the arbiter SHALL NOT recompute it.
REQ-024 RESP behaviour:
- RespValid=1 and all Resp* outputs are stable until the handshake.
- RespValid & RespReady: go to IDLE.
- Otherwise: stay in RESP with no new grant.
REQ-025 Latency: an operation accepted at cycle N SHALL show RespValid=1 at cycle N+2.
REQ-026 Throughput: minimum issue spacing SHALL be 3 cycles.
REQ-027 A request that is held valid but not granted SHALL NOT be dropped; the arbiter relies on the requester keeping ReqnValid asserted until it sees ReqnReady.
REQ-028 RespReady SHALL be ignored outside RESP.

Reset
REQ-029 Reset SHALL be synchronous and active-high, and SHALL override all other inputs on any cycle.
REQ-030 Reset values SHALL be:
- state=IDLE, LastGrant=1.
- ReqnReady=0 during reset, RespValid=0.
- RespId=0, RespW=0, RespZero=0, RespErr=0.
- AluBusA=0, AluBusB=0, AluCtrl=0000 (AND).
REQ-031 Reset in EXEC or RESP SHALL discard the in-flight operation without producing a response.

Structure
REQ-032 A shared package SHALL hold the op-code constants, the legal-code check, and the FSM state encoding (2 bits).
REQ-033 The round-robin grant logic SHALL be one sub-module, rr_arb2, with inputs Valid[1:0] and LastGrant and a one-hot Grant[1:0] output.
REQ-034 The ALU SHALL stay external; this block only drives it and samples it.

Verification
REQ-035 Single op: Req0 ADD A=5, B=7 at cycle 0, RespReady=1.
- Req0Ready=1 at cycle 0.
- RespValid=1 at cycle 2 with RespId=0, RespW=12, RespZero=0, RespErr=0.
REQ-036 Tie: both requests valid at the same time, from reset.
- Req0 is served first, then Req1, then Req0, alternating.
- A non-granted request is never lost.
REQ-037 Backpressure: hold RespReady=0 for 5 cycles.
- RespValid and RespW stay stable.
- No ReqnReady is asserted until the handshake completes.
REQ-038 Illegal op: Req1Ctrl=1111.
- RespErr=1, RespW=0.
- AluCtrl keeps its prior value for the whole operation.
REQ-039 Zero flag: SUB with A=9, B=0 gives RespW=9 and RespZero=1, because AluZero is forwarded from the ALU.
REQ-040 Reset in EXEC: assert Reset for one cycle.
- The next cycle shows IDLE, RespValid=0 and all outputs at their reset values.
- No response is ever issued for the discarded operation.
